// File: rtl/mlp_controller.sv
// mlp_controller: sequences the MLP datapath through one inference.
// It runs three hidden-layer passes of input_size neurons each, then one
// output-layer pass, and finally captures the label from the datapath.
// All outputs are registered: the next-state logic also computes the
// outputs for the next state, and one register stage holds both.
// Optional build macro MLP_CTRL_PERF_EN adds the inference_count and
// last_latency outputs. Core timing is the same with or without it.
//
// state | meaning
// IDLE  | waiting for start, curr_layer = 0
// LOAD  | data_ld strobe latches the input sample
// EVAL  | curr_layer held for settle_cycles while the PUs settle
// WRITE | ld_en group of the current hidden layer loads its results
// LATCH | curr_layer = 3, label_in captured at the end of this cycle
// DONE  | one-cycle done pulse, label valid
module mlp_controller #(
    parameter int input_size                 = 10,
    parameter int size_of_hidden_layer       = 30,
    parameter int clog2_size_of_output_layer = 4,
    parameter int settle_cycles              = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [clog2_size_of_output_layer-1:0] label_in,
    output logic                                  busy,
    output logic                                  data_ld,
    output logic [1:0]                            curr_layer,
    output logic [size_of_hidden_layer-1:0]       ld_en,
    output logic [clog2_size_of_output_layer-1:0] label,
    output logic                                  done
`ifdef MLP_CTRL_PERF_EN
    ,
    output logic [15:0]                           inference_count,
    output logic [7:0]                            last_latency
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic [1:0] layer_q, layer_d;
    logic [3:0] cnt_q, cnt_d;

    logic                                  busy_d;
    logic                                  data_ld_d;
    logic [1:0]                            curr_layer_d;
    logic [size_of_hidden_layer-1:0]       ld_en_d;
    logic [clog2_size_of_output_layer-1:0] label_d;
    logic                                  done_d;

    // Next state, layer/settle counters and label capture.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        label_d = label;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = EVAL;
                layer_d = 2'd0;
                cnt_d   = 4'd0;
            end
            EVAL: begin
                if (cnt_q == 4'(settle_cycles - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = (layer_q < 2'd3) ? WRITE : LATCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                state_d = EVAL;
                layer_d = layer_q + 2'd1;
                cnt_d   = 4'd0;
            end
            LATCH: begin
                label_d = label_in;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                layer_d = 2'd0;
            end
            default: begin
                state_d = IDLE;
                layer_d = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they can be registered.
    always_comb begin
        busy_d       = (state_d != IDLE);
        data_ld_d    = (state_d == LOAD);
        done_d       = (state_d == DONE);
        curr_layer_d = 2'd0;
        ld_en_d      = '0;
        case (state_d)
            EVAL, WRITE: curr_layer_d = layer_d;
            LATCH, DONE: curr_layer_d = 2'd3;
            default:     curr_layer_d = 2'd0;
        endcase
        for (int g = 0; g < 3; g++) begin
            ld_en_d[g*input_size +: input_size] =
                {input_size{(state_d == WRITE) && (layer_d == 2'(g))}};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            layer_q    <= 2'd0;
            cnt_q      <= 4'd0;
            busy       <= 1'b0;
            data_ld    <= 1'b0;
            curr_layer <= 2'd0;
            ld_en      <= '0;
            label      <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            data_ld    <= data_ld_d;
            curr_layer <= curr_layer_d;
            ld_en      <= ld_en_d;
            label      <= label_d;
            done       <= done_d;
        end
    end

`ifdef MLP_CTRL_PERF_EN
    logic [7:0]  lat_q, lat_d;
    logic [15:0] inference_count_d;
    logic [7:0]  last_latency_d;

    // lat_q counts the cycles of the current inference, LOAD = 1.
    // Results are loaded on entry to DONE so they are valid with done.
    always_comb begin
        lat_d             = lat_q;
        inference_count_d = inference_count;
        last_latency_d    = last_latency;
        if (state_d == LOAD) begin
            lat_d = 8'd1;
        end else if (busy && (lat_q != 8'hFF)) begin
            lat_d = lat_q + 8'd1;
        end
        if (state_d == DONE) begin
            inference_count_d = inference_count + 16'd1;
            last_latency_d    = (lat_q == 8'hFF) ? 8'hFF : lat_q + 8'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q           <= 8'd0;
            inference_count <= 16'd0;
            last_latency    <= 8'd0;
        end else begin
            lat_q           <= lat_d;
            inference_count <= inference_count_d;
            last_latency    <= last_latency_d;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_controller.sv
// Bench for mlp_controller: one instance with settle_cycles=2 and one with
// settle_cycles=1. A fixed table covers the first inference, and a
// cycle-by-cycle scoreboard covers back-to-back, reset and random starts.
module tb_mlp_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, busy_a, dl_a, done_a;
    logic [3:0]  lin_a, lab_a;
    logic [1:0]  cl_a;
    logic [29:0] ld_a;
    logic        rst_b, start_b, busy_b, dl_b, done_b;
    logic [3:0]  lin_b, lab_b;
    logic [1:0]  cl_b;
    logic [29:0] ld_b;
`ifdef MLP_CTRL_PERF_EN
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  lat_a, lat_b;
`endif

    mlp_controller #(.settle_cycles(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .label_in(lin_a),
        .busy(busy_a), .data_ld(dl_a), .curr_layer(cl_a), .ld_en(ld_a),
        .label(lab_a), .done(done_a)
`ifdef MLP_CTRL_PERF_EN
        , .inference_count(cnt_a), .last_latency(lat_a)
`endif
    );

    mlp_controller #(.settle_cycles(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .label_in(lin_b),
        .busy(busy_b), .data_ld(dl_b), .curr_layer(cl_b), .ld_en(ld_b),
        .label(lab_b), .done(done_b)
`ifdef MLP_CTRL_PERF_EN
        , .inference_count(cnt_b), .last_latency(lat_b)
`endif
    );

    typedef struct {
        logic        busy;
        logic        data_ld;
        logic [1:0]  cl;
        logic [29:0] ld;
        logic        done;
        logic [3:0]  label;
        logic        is_latch;
        logic [3:0]  lat_val;
        logic [15:0] cnt;
        logic [7:0]  lat;
    } rec_t;

    typedef struct {
        logic        start;
        logic        busy;
        logic        data_ld;
        logic [1:0]  cl;
        logic [29:0] ld;
        logic        done;
    } row_t;

    rec_t exp_q[$];
    row_t tbl[16];
    int checks = 0;
    int fails  = 0;
    logic [3:0]  m_label;
    logic [15:0] m_count;
    logic [7:0]  m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic r, input logic st, input logic [3:0] lin);
        if (sel == 0) begin
            rst_a = r; start_a = st; lin_a = lin;
        end else begin
            rst_b = r; start_b = st; lin_b = lin;
        end
    endtask

    task automatic compare(input int sel, input rec_t e, input string tag);
        logic        b, d, dn;
        logic [1:0]  c;
        logic [29:0] l;
        logic [3:0]  lb;
        b  = sel == 0 ? busy_a : busy_b;
        d  = sel == 0 ? dl_a   : dl_b;
        dn = sel == 0 ? done_a : done_b;
        c  = sel == 0 ? cl_a   : cl_b;
        l  = sel == 0 ? ld_a   : ld_b;
        lb = sel == 0 ? lab_a  : lab_b;
        chk({tag, ".busy"},       32'(b),  32'(e.busy));
        chk({tag, ".data_ld"},    32'(d),  32'(e.data_ld));
        chk({tag, ".curr_layer"}, 32'(c),  32'(e.cl));
        chk({tag, ".ld_en"},      32'(l),  32'(e.ld));
        chk({tag, ".done"},       32'(dn), 32'(e.done));
        chk({tag, ".label"},      32'(lb), 32'(e.label));
`ifdef MLP_CTRL_PERF_EN
        chk({tag, ".inference_count"}, 32'(sel == 0 ? cnt_a : cnt_b), 32'(e.cnt));
        chk({tag, ".last_latency"},    32'(sel == 0 ? lat_a : lat_b), 32'(e.lat));
`endif
    endtask

    // Expected outputs k cycles after the edge that samples start.
    function automatic rec_t model(input int s, input int k);
        rec_t r;
        int j, p, lyr, pos, m;
        r = '{default: '0};
        r.busy = 1'b1;
        if (k == 1) begin
            r.data_ld = 1'b1;
        end else begin
            j = k - 2;
            p = s + 1;
            if (j < 3 * p) begin
                lyr  = j / p;
                pos  = j % p;
                r.cl = 2'(lyr);
                if (pos == s) r.ld = 30'h3FF << (10 * lyr);
            end else begin
                m    = j - 3 * p;
                r.cl = 2'd3;
                if (m == s)     r.is_latch = 1'b1;
                if (m == s + 1) r.done     = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic push_idle();
        rec_t r;
        r = '{default: '0};
        r.label = m_label;
        r.cnt   = m_count;
        r.lat   = m_last;
        exp_q.push_back(r);
    endtask

    task automatic push_inference(input int s);
        rec_t r;
        int len;
        logic [3:0] v;
        len = 4 * s + 6;
        v   = 4'($urandom_range(1, 15));
        for (int k = 1; k <= len; k++) begin
            r         = model(s, k);
            r.lat_val = v;
            r.label   = (k == len) ? v : m_label;
            r.cnt     = (k == len) ? m_count + 16'd1 : m_count;
            r.lat     = (k == len) ? ((len > 255) ? 8'hFF : 8'(len)) : m_last;
            exp_q.push_back(r);
        end
        m_label = v;
        m_count = m_count + 16'd1;
        m_last  = 8'(len);
    endtask

    // mode 0: start held high; 1: pulses at c=0 and c=pulse2; 2: random.
    task automatic sb_run(input int sel, input int s, input int ncyc, input int mode,
                          input int rst_at, input int pulse2, input string tag);
        rec_t cur;
        logic st, r;
        logic [3:0] lin;
        exp_q.delete();
        m_label = 4'd0; m_count = 16'd0; m_last = 8'd0;
        drive(sel, 1'b1, 1'b0, 4'd0);
        tick();
        drive(sel, 1'b0, 1'b0, 4'd0);
        push_idle();
        for (int c = 0; c < ncyc; c++) begin
            cur = exp_q.pop_front();
            compare(sel, cur, tag);
            case (mode)
                0:       st = 1'b1;
                1:       st = (c == 0) || (c == pulse2);
                default: st = ($urandom_range(0, 3) == 0);
            endcase
            r   = (c == rst_at);
            lin = cur.is_latch ? cur.lat_val : 4'($urandom_range(0, 15));
            drive(sel, r, st, lin);
            if (r) begin
                exp_q.delete();
                m_label = 4'd0; m_count = 16'd0; m_last = 8'd0;
                push_idle();
            end else if (exp_q.size() == 0) begin
                if (!cur.busy && st) push_inference(s);
                else push_idle();
            end
            tick();
        end
        drive(sel, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic table_pass(input int pass_n, input logic [3:0] latch_v, input logic [3:0] prev);
        rec_t e;
        logic st;
        for (int r = 0; r < 16; r++) begin
            e         = '{default: '0};
            e.busy    = tbl[r].busy;
            e.data_ld = tbl[r].data_ld;
            e.cl      = tbl[r].cl;
            e.ld      = tbl[r].ld;
            e.done    = tbl[r].done;
            e.label   = (r >= 14) ? latch_v : prev;
            e.cnt     = (r >= 14) ? 16'(pass_n + 1) : 16'(pass_n);
            e.lat     = (r >= 14 || pass_n > 0) ? 8'd14 : 8'd0;
            compare(0, e, pass_n == 0 ? "tbl" : "tbl_ign");
            st = tbl[r].start | ((pass_n == 1) && (r == 3 || r == 14));
            drive(0, 1'b0, st, (r == 13) ? latch_v : 4'd2);
            tick();
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 30'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 30'h0,        1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 30'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 30'h0,        1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 30'h3FF,      1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 30'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 30'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd1, 30'hFFC00,    1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 30'h0,        1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 30'h0,        1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd2, 30'h3FF00000, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 30'h0,        1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd3, 30'h0,        1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 30'h0,        1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd3, 30'h0,        1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 30'h0,        1'b0};

        rst_a = 1'b1; start_a = 1'b0; lin_a = 4'd0;
        rst_b = 1'b1; start_b = 1'b0; lin_b = 4'd0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        table_pass(0, 4'd7, 4'd0);
        table_pass(1, 4'd5, 4'd7);

        sb_run(0, 2, 40, 0, -1, -1, "held");
        sb_run(0, 2, 45, 1, 8, 12, "midrst");
        sb_run(1, 1, 20, 1, -1, -1, "settle1");
        sb_run(1, 1, 120, 2, 60, -1, "rand1");
        sb_run(0, 2, 120, 2, 75, -1, "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
